pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform
//  and reports its period and high time in clk cycles, using the same period /

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_sync_edge.sv | 47 ++++
 rtl/pwm_capture.sv | 157 +++++++++++++++
 tb/tb_pwm_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM capture block: default counter width and the
// capture FSM state encoding (2 bits).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package pwm_pkg;

    // Default width of the cycle counter and of the period/duty_cycle outputs.
    localparam int unsigned PWM_WIDTH = 16;

    // Capture FSM states.
    //   ST_IDLE : disabled, counter cleared
    //   ST_ARM  : waiting for the first rising edge (partial period discarded)
    //   ST_HIGH : input high, counting high time
    //   ST_LOW  : input low, counting remainder of the period
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Brings the asynchronous PWM input into the clk domain through a flip-flop
// synchronizer and detects edges on the synchronized level.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   asynchronous input level
//   s         out  synchronized level (last synchronizer stage)
//   rise      out  s went 0 -> 1 this cycle
//   fall      out  s went 1 -> 0 this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        s_dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;

endmodule : pwm_sync_edge

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures an incoming PWM waveform: period and high time in clk cycles,
// in the same units the PWM generator takes. Reports a timeout when no edge
// is seen for 2^WIDTH-1 cycles, with the level the input was stuck at.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   capture enable; 0 forces IDLE
//   pwm_in       in   asynchronous PWM input
//   period       out  clk cycles between the last two rising edges
//   duty_cycle   out  clk cycles high within that period
//   valid        out  1-cycle pulse, period/duty_cycle just updated
//   timeout      out  1-cycle pulse, no edge for 2^WIDTH-1 cycles
//   stuck_level  out  pwm_in level at last timeout; cleared on valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic s, rise, fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pwm_in),
        .s        (s),
        .rise     (rise),
        .fall     (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_q, stuck_d;

    logic             at_max;
    logic             any_edge;
    logic [WIDTH-1:0] cnt_inc;

    always_comb begin
        at_max   = (cnt_q == CNT_MAX);
        any_edge = rise | fall;
        // Saturating increment: an edge landing exactly on CNT_MAX holds the
        // count and lets the timeout fire on the following edgeless cycle.
        cnt_inc  = at_max ? cnt_q : cnt_q + CNT_ONE;

        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cnt_d = high_cnt_q;
        period_d   = period_q;
        duty_d     = duty_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        stuck_d    = stuck_q;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q != ST_IDLE && at_max && !any_edge) begin
            timeout_d = 1'b1;
            stuck_d   = s;
            cnt_d     = '0;
            state_d   = ST_ARM;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        high_cnt_d = cnt_q;
                        state_d    = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d = cnt_q;
                        duty_d   = high_cnt_q;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b0;
                        cnt_d    = CNT_ONE;
                        state_d  = ST_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cnt_q <= high_cnt_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            stuck_q    <= stuck_d;
        end
    end

    assign period      = period_q;
    assign duty_cycle  = duty_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign stuck_level = stuck_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Directed bench for pwm_capture. A narrow 8-bit counter keeps the timeout
// interval at 255 cycles. A simple PWM generator drives pwm_in; new
// period/duty settings take effect at the start of a generator period.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] duty_cycle;
    logic         valid;
    logic         timeout;
    logic         stuck_level;

    int tests = 0;
    int fails = 0;

    int valid_cnt = 0;
    int to_cnt    = 0;

    bit gen_on    = 1'b0;
    bit force_lvl = 1'b0;
    int period_nx = 10;
    int duty_nx   = 3;
    int gen_period = 10;
    int gen_duty   = 3;
    int phase      = 0;

    pwm_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pwm_in      (pwm_in),
        .period      (period),
        .duty_cycle  (duty_cycle),
        .valid       (valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gen_on) begin
            if (phase == 0) begin
                gen_period = period_nx;
                gen_duty   = duty_nx;
            end
            pwm_in = (phase < gen_duty);
            phase  = (phase + 1 >= gen_period) ? 0 : phase + 1;
        end else begin
            phase  = 0;
            pwm_in = force_lvl;
        end
    end

    always @(negedge clk) begin
        if (valid === 1'b1)   valid_cnt++;
        if (timeout === 1'b1) to_cnt++;
    end

    task automatic wait_valid(input int max_cyc, output bit found, output int cyc);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_timeout(input int max_cyc, output bit found);
        int cyc;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (timeout === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_phase(input int ph, output bit found);
        int cyc;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 200) begin
            @(posedge clk);
            cyc++;
            if (phase == ph) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (period !== 8'd0) begin fails++; $display("FAIL reset_period got=%0d exp=0", period); end
        tests++; if (duty_cycle !== 8'd0) begin fails++; $display("FAIL reset_duty got=%0d exp=0", duty_cycle); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        tests++; if (stuck_level !== 1'b0) begin fails++; $display("FAIL reset_stuck got=%b exp=0", stuck_level); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_loopback;
        bit found;
        int cyc;
        period_nx = 10;
        duty_nx   = 3;
        @(negedge clk);
        gen_on = 1'b1;
        en     = 1'b1;
        wait_valid(60, found, cyc);
        tests++; if (!found) begin fails++; $display("FAIL loop_first_valid got=none exp=valid within 60"); end
        tests++; if (period !== 8'd10) begin fails++; $display("FAIL loop_period got=%0d exp=10", period); end
        tests++; if (duty_cycle !== 8'd3) begin fails++; $display("FAIL loop_duty got=%0d exp=3", duty_cycle); end
        for (int i = 0; i < 3; i++) begin
            wait_valid(30, found, cyc);
            tests++; if (!found || cyc != 10) begin fails++; $display("FAIL loop_interval got=%0d found=%b exp=10", cyc, found); end
            tests++; if (period !== 8'd10 || duty_cycle !== 8'd3) begin fails++; $display("FAIL loop_values got=%0d/%0d exp=10/3", period, duty_cycle); end
        end
    endtask

    task automatic test_duty_change;
        bit found;
        int cyc;
        period_nx = 100;
        duty_nx   = 30;
        repeat (2) wait_valid(250, found, cyc);
        wait_valid(250, found, cyc);
        tests++; if (!found || period !== 8'd100 || duty_cycle !== 8'd30) begin
            fails++; $display("FAIL dc_initial got=%0d/%0d found=%b exp=100/30", period, duty_cycle, found);
        end
        duty_nx = 70;
        for (int i = 0; i < 3; i++) begin
            wait_valid(250, found, cyc);
            tests++; if (!found || period !== 8'd100 || (duty_cycle !== 8'd30 && duty_cycle !== 8'd70)) begin
                fails++; $display("FAIL dc_step got=%0d/%0d found=%b exp=100/(30|70)", period, duty_cycle, found);
            end
        end
        tests++; if (duty_cycle !== 8'd70) begin fails++; $display("FAIL dc_final got=%0d exp=70", duty_cycle); end
    endtask

    task automatic test_timeout;
        bit found;
        bit vfound;
        int cyc;
        int v0;
        @(posedge clk); #2;
        gen_on    = 1'b0;
        force_lvl = 1'b0;
        v0 = valid_cnt;
        wait_timeout(400, found);
        tests++; if (!found) begin fails++; $display("FAIL to_low_pulse got=none exp=timeout within 400"); end
        tests++; if (stuck_level !== 1'b0) begin fails++; $display("FAIL to_low_stuck got=%b exp=0", stuck_level); end
        tests++; if (period !== 8'd100 || duty_cycle !== 8'd70) begin
            fails++; $display("FAIL to_hold got=%0d/%0d exp=100/70", period, duty_cycle);
        end
        @(posedge clk); #1;
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_width got=%b exp=0", timeout); end
        force_lvl = 1'b1;
        wait_timeout(400, found);
        tests++; if (!found || stuck_level !== 1'b1) begin
            fails++; $display("FAIL to_high_stuck got=%b found=%b exp=1", stuck_level, found);
        end
        tests++; if (valid_cnt != v0) begin fails++; $display("FAIL to_no_valid got=%0d exp=0", valid_cnt - v0); end
        period_nx = 10;
        duty_nx   = 3;
        gen_on    = 1'b1;
        wait_valid(100, vfound, cyc);
        tests++; if (!vfound || stuck_level !== 1'b0) begin
            fails++; $display("FAIL to_resume_clear got=%b found=%b exp=0", stuck_level, vfound);
        end
        tests++; if (period !== 8'd10 || duty_cycle !== 8'd3) begin
            fails++; $display("FAIL to_resume_values got=%0d/%0d exp=10/3", period, duty_cycle);
        end
    endtask

    task automatic test_min_period;
        bit found;
        int cyc;
        int v0;
        int t0;
        period_nx = 2;
        duty_nx   = 1;
        repeat (2) wait_valid(40, found, cyc);
        wait_valid(40, found, cyc);
        tests++; if (!found || period !== 8'd2 || duty_cycle !== 8'd1) begin
            fails++; $display("FAIL min_values got=%0d/%0d found=%b exp=2/1", period, duty_cycle, found);
        end
        for (int i = 0; i < 2; i++) begin
            wait_valid(10, found, cyc);
            tests++; if (!found || cyc != 2) begin fails++; $display("FAIL min_interval got=%0d found=%b exp=2", cyc, found); end
        end
        // duty 0: constant low
        duty_nx = 0;
        repeat (10) @(posedge clk);
        v0 = valid_cnt;
        t0 = to_cnt;
        repeat (600) @(posedge clk);
        #1;
        tests++; if (valid_cnt != v0 || to_cnt == t0 || stuck_level !== 1'b0) begin
            fails++; $display("FAIL duty0 got=valids %0d timeouts %0d stuck %b exp=0/>0/0", valid_cnt - v0, to_cnt - t0, stuck_level);
        end
        // duty == period: constant high
        period_nx = 10;
        duty_nx   = 10;
        repeat (10) @(posedge clk);
        v0 = valid_cnt;
        t0 = to_cnt;
        repeat (600) @(posedge clk);
        #1;
        tests++; if (valid_cnt != v0 || to_cnt == t0 || stuck_level !== 1'b1) begin
            fails++; $display("FAIL duty100 got=valids %0d timeouts %0d stuck %b exp=0/>0/1", valid_cnt - v0, to_cnt - t0, stuck_level);
        end
    endtask

    task automatic test_en_drop;
        bit found;
        int cyc;
        int v0;
        period_nx = 20;
        duty_nx   = 10;
        repeat (2) wait_valid(100, found, cyc);
        wait_valid(100, found, cyc);
        tests++; if (!found || period !== 8'd20 || duty_cycle !== 8'd10) begin
            fails++; $display("FAIL en_pre got=%0d/%0d found=%b exp=20/10", period, duty_cycle, found);
        end
        wait_phase(7, found);
        tests++; if (!found) begin fails++; $display("FAIL en_phase got=none exp=phase 7"); end
        #2;
        en = 1'b0;
        v0 = valid_cnt;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (valid_cnt != v0 || period !== 8'd20 || duty_cycle !== 8'd10) begin
            fails++; $display("FAIL en_off_hold got=valids %0d %0d/%0d exp=0 20/10", valid_cnt - v0, period, duty_cycle);
        end
        en = 1'b1;
        wait_valid(100, found, cyc);
        tests++; if (!found || cyc <= 20) begin fails++; $display("FAIL en_reenable_latency got=%0d found=%b exp=>20", cyc, found); end
        tests++; if (period !== 8'd20 || duty_cycle !== 8'd10) begin
            fails++; $display("FAIL en_reenable_values got=%0d/%0d exp=20/10", period, duty_cycle);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int cyc;
        wait_phase(16, found);
        tests++; if (!found) begin fails++; $display("FAIL rm_phase got=none exp=phase 16"); end
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (period !== 8'd0 || duty_cycle !== 8'd0 || valid !== 1'b0 || timeout !== 1'b0 || stuck_level !== 1'b0) begin
            fails++; $display("FAIL rm_clear got=%0d/%0d v%b t%b s%b exp=0/0 v0 t0 s0", period, duty_cycle, valid, timeout, stuck_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(100, found, cyc);
        tests++; if (!found || period !== 8'd20 || duty_cycle !== 8'd10) begin
            fails++; $display("FAIL rm_resume got=%0d/%0d found=%b exp=20/10", period, duty_cycle, found);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_duty_change();
        test_timeout();
        test_min_period();
        test_en_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pwm_capture
